add_operand_feeder: RTL



---
 rtl/add_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/add_operand_feeder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_pkg
// Description : Shared definitions for the add/sub datapath: operation tag
//               encoding, feeder FSM state type and pair counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package add_pkg;

    // Operation tag carried with every operand word
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of the issued-pair counter
    localparam int PAIR_COUNT_W = 16;

    // Pairing FSM: collect A, collect B, then present the pair
    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        ISSUE  = 2'd2
    } feeder_state_t;

endpackage : add_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered occupancy count, flush and
//               fall-through read data (head word visible on rdata).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int            c_addr_w     = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full_count = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wptr;
    logic [c_addr_w-1:0] r_rptr;
    logic [c_addr_w:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    // Flags come straight from the registered count, so a pop never frees
    // space for a push in the same cycle.
    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;
    assign rdata     = r_mem[r_rptr];

    // Storage array: written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush empties the FIFO and drops a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/add_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : add_operand_feeder
// Description : Buffers incoming operand words, pairs consecutive words into
//               (A, B) with the A word's op tag, and presents each pair with
//               registered outputs over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module add_operand_feeder
    import add_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_op,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_a,
    output logic [DATA_WIDTH-1:0]   out_b,
    output logic                    out_op,
    output logic [PAIR_COUNT_W-1:0] pair_count
);

    // FIFO entries carry {op, data}
    localparam int c_entry_w = DATA_WIDTH + 1;

    feeder_state_t           r_state;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_a;
    logic [DATA_WIDTH-1:0]   r_out_b;
    logic                    r_out_op;
    logic [PAIR_COUNT_W-1:0] r_pair_count;

    logic [c_entry_w-1:0]    w_fifo_wdata;
    logic [c_entry_w-1:0]    w_fifo_rdata;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_fifo_pop;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    w_head_op;

    assign w_fifo_wdata = {in_op, in_data};
    assign w_head_data  = w_fifo_rdata[DATA_WIDTH-1:0];
    assign w_head_op    = w_fifo_rdata[DATA_WIDTH];

    // Pop only while collecting operands; a flush cycle never captures a word
    // that is being discarded.
    assign w_fifo_pop = !flush && !w_fifo_empty &&
                        ((r_state == WAIT_A) || (r_state == WAIT_B));

    sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (in_valid),
        .pop   (w_fifo_pop),
        .wdata (w_fifo_wdata),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign in_ready   = !w_fifo_full;
    assign out_valid  = r_out_valid;
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_op     = r_out_op;
    assign pair_count = r_pair_count;

    // Pairing FSM with registered pair outputs and issued-pair counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_A;
            r_out_valid  <= 1'b0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_op     <= OP_ADD;
            r_pair_count <= '0;
        end else begin
            case (r_state)
                WAIT_A: begin
                    if (!flush && !w_fifo_empty) begin
                        r_out_a  <= w_head_data;
                        r_out_op <= w_head_op;
                        r_state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A flush abandons the half-built pair
                    if (flush) begin
                        r_state <= WAIT_A;
                    end else if (!w_fifo_empty) begin
                        r_out_b     <= w_head_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Pending pair is held through flush until accepted
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_pair_count <= r_pair_count + 1'b1;
                        r_state      <= WAIT_A;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= WAIT_A;
                end
            endcase
        end
    end

endmodule : add_operand_feeder
`default_nettype wire
